lander_step_seq: RTL

LANDER_STEP_SEQ -- requirements
Module: lander_step_seq

---
 rtl/lander_step_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/lander_step_seq.sv
// One lunar-lander physics tick per step request, sequenced over a shared
// external BCD add/sub unit; one adder operation per cycle.
module lander_step_seq #(
  parameter logic [15:0] FUEL_INIT   = 16'h0800,
  parameter logic [15:0] ALT_INIT    = 16'h4500,
  parameter logic [15:0] VEL_INIT    = 16'h0000,
  parameter logic [15:0] THRUST_INIT = 16'h0005,
  parameter logic [15:0] GRAV        = 16'h0005,
  parameter logic [15:0] SAFE_VEL    = 16'h9970,
  parameter logic [15:0] SAFE_THRUST = 16'h0005
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [3:0]  thrust_req,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_op,
  input  logic [15:0] add_s,
  output logic [15:0] alt,
  output logic [15:0] vel,
  output logic [15:0] fuel,
  output logic [15:0] thrust,
  output logic        busy,
  output logic        done,
  output logic        landed,
  output logic        crashed
);

  typedef enum logic [2:0] {IDLE, S_ALT, S_VG, S_VT, S_FU, S_CMT, HALT} state_t;

  state_t      state;
  logic [15:0] tmp, alt_n, vel_n, fuel_n;
  logic [3:0]  thr_lat;

  // Adder operands are registered one cycle ahead: each transition loads the
  // operands the next state needs, so add_s is valid throughout that state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      alt     <= ALT_INIT;
      vel     <= VEL_INIT;
      fuel    <= FUEL_INIT;
      thrust  <= THRUST_INIT;
      tmp     <= '0;
      alt_n   <= '0;
      vel_n   <= '0;
      fuel_n  <= '0;
      thr_lat <= THRUST_INIT[3:0];
      busy    <= 1'b0;
      done    <= 1'b0;
      landed  <= 1'b0;
      crashed <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      add_op  <= 1'b0;
    end else begin
      done   <= 1'b0;
      add_a  <= '0;
      add_b  <= '0;
      add_op <= 1'b0;
      case (state)
        IDLE: if (step) begin
          thr_lat <= thrust_req;
          state   <= S_ALT;
          busy    <= 1'b1;
          add_a   <= alt;
          add_b   <= vel;
        end
        S_ALT: begin
          alt_n  <= add_s;
          state  <= S_VG;
          add_a  <= vel;
          add_b  <= GRAV;
          add_op <= 1'b1;
        end
        S_VG: begin
          tmp   <= add_s;
          state <= S_VT;
          add_a <= add_s;
          add_b <= thrust;
        end
        S_VT: begin
          vel_n  <= add_s;
          state  <= S_FU;
          add_a  <= fuel;
          add_b  <= thrust;
          add_op <= 1'b1;
        end
        S_FU: begin
          fuel_n <= add_s;
          state  <= S_CMT;
        end
        S_CMT: begin
          alt  <= alt_n;
          vel  <= vel_n;
          fuel <= fuel_n[15] ? 16'h0000 : fuel_n;
          // Out of fuel (now or after this burn) kills the engine; a non-BCD
          // request keeps the current setting.
          if (fuel == 16'h0000 || fuel_n[15])
            thrust <= 16'h0000;
          else if (thr_lat <= 4'd9)
            thrust <= {12'h000, thr_lat};
          busy <= 1'b0;
          done <= 1'b1;
          // Checks use the thrust that was applied during this tick.
          if (vel_n > SAFE_VEL && alt_n[15] && thrust <= SAFE_THRUST) begin
            landed <= 1'b1;
            state  <= HALT;
          end else if (alt_n[15]) begin
            crashed <= 1'b1;
            state   <= HALT;
          end else begin
            state <= IDLE;
          end
        end
        HALT: begin
          alt <= '0;
          vel <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
